// File: rtl/ysyx_22050019_div_req.sv
// -----------------------------------------------------------------------------
// ysyx_22050019_div_req
//
// EXU-side requester for the iterative 64/64 divider. It accepts one RV64M
// div/rem op from EX, translates funct3/word into the divider's one-hot
// operation type, and issues it with a single div_valid pulse. EX is held while
// an op is outstanding. The divider's result is buffered and presented to WB
// with a valid/ready handshake. A flush kills any accepted op that has not yet
// retired. If that op is already inside the divider, the requester waits for
// the divider to finish and discards the result. This keeps the divider and the
// requester in lock-step.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     EX request handshake (in_ready == state IDLE)
//   in_funct3, in_word    op select: 100 DIV, 101 DIVU, 110 REM, 111 REMU; word=1 -> *W
//   in_rs1, in_rs2        dividend, divisor
//   in_rd                 destination register index
//   flush                 kill the accepted, not-yet-retired op
//   ex_stall              in_valid & ~in_ready
//   div_valid             one-cycle start pulse to the divider
//   div_type_o            one-hot op type (REM 80 REMU 40 REMUW 20 REMW 10
//                                          DIV 08 DIVU 04 DIVUW 02 DIVW 01)
//   dividend_o, divisor_o registered operands, stable from REQ until result_ok
//   div_stall             divider busy; observed only
//   result_ok/result_ready divider result handshake, data on div_out
//   wb_valid/wb_ready     WB handshake, data on wb_data / wb_rd
//   dbg_state_o           current FSM state, for observation only
//
// Configuration
//   DIV_REQ_BYPASS_EN  when defined, a divisor of 1 (low 32 bits for *W) is
//                      resolved locally. The op goes straight from IDLE to DONE
//                      and the divider is never started for it.
//
// Handshake semantics (every valid/ready pair in this block):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   A valid, once raised, holds its payload stable until that transfer. Ready
//   may be raised without a pending valid. Here all ready signals are decoded
//   purely from the state register, so they never depend on the matching valid.
// -----------------------------------------------------------------------------
module ysyx_22050019_div_req #(
    parameter int XLEN = 64,
    parameter int RIDX = 5
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic            in_word,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [RIDX-1:0] in_rd,
    input  logic            flush,
    output logic            ex_stall,

    output logic            div_valid,
    output logic [7:0]      div_type_o,
    output logic [XLEN-1:0] dividend_o,
    output logic [XLEN-1:0] divisor_o,
    input  logic            div_stall,
    input  logic            result_ok,
    input  logic [XLEN-1:0] div_out,
    output logic            result_ready,

    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [XLEN-1:0] wb_data,
    output logic [RIDX-1:0] wb_rd,

    output logic [2:0]      dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_DONE  = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        type_q, type_d;
    logic [XLEN-1:0]   dividend_q, dividend_d;
    logic [XLEN-1:0]   divisor_q, divisor_d;
    logic [RIDX-1:0]   rd_q, rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;

    logic [7:0]        type_enc;
    logic              accept;

    // The divider busy flag carries no information this FSM needs: the
    // divider always takes a start while idle, and result_ok alone ends WAIT
    // or DRAIN.
    logic              div_stall_unused;
    assign div_stall_unused = div_stall;

    // funct3[1] selects rem, funct3[0] selects unsigned, in_word selects *W.
    // funct3[2] only qualifies the op as div/rem, so it is used in accept.
    always_comb begin
        type_enc = 8'h00;
        unique case ({in_funct3[1:0], in_word})
            3'b000:  type_enc = 8'h08; // DIV
            3'b001:  type_enc = 8'h01; // DIVW
            3'b010:  type_enc = 8'h04; // DIVU
            3'b011:  type_enc = 8'h02; // DIVUW
            3'b100:  type_enc = 8'h80; // REM
            3'b101:  type_enc = 8'h10; // REMW
            3'b110:  type_enc = 8'h40; // REMU
            3'b111:  type_enc = 8'h20; // REMUW
            default: type_enc = 8'h00;
        endcase
    end

    // Only funct3 = 1xx is a div/rem op. Anything else is ignored without
    // ever leaving IDLE. A flush in the same cycle also blocks acceptance.
    assign accept = in_valid & ~flush & in_funct3[2];

`ifdef DIV_REQ_BYPASS_EN
    // Divide-by-one shortcut. A quotient is the dividend and a remainder is
    // zero. For *W ops only the low word matters, and the result is
    // sign-extended from bit 31.
    logic              byp_hit;
    logic [XLEN-1:0]   byp_data;

    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        if (in_word) begin
            byp_hit = (in_rs2[31:0] == 32'd1);
            if (!in_funct3[1]) begin
                byp_data = {{(XLEN-32){in_rs1[31]}}, in_rs1[31:0]};
            end
        end else begin
            byp_hit = (in_rs2 == XLEN'(1));
            if (!in_funct3[1]) begin
                byp_data = in_rs1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            type_q     <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            rd_q       <= '0;
            wb_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            rd_q       <= rd_d;
            wb_data_q  <= wb_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        type_d       = type_q;
        dividend_d   = dividend_q;
        divisor_d    = divisor_q;
        rd_d         = rd_q;
        wb_data_d    = wb_data_q;
        in_ready     = 1'b0;
        div_valid    = 1'b0;
        result_ready = 1'b0;
        wb_valid     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (accept) begin
                    type_d     = type_enc;
                    dividend_d = in_rs1;
                    divisor_d  = in_rs2;
                    rd_d       = in_rd;
`ifdef DIV_REQ_BYPASS_EN
                    if (byp_hit) begin
                        wb_data_d = byp_data;
                        state_d   = S_DONE;
                    end else begin
                        state_d   = S_REQ;
                    end
`else
                    state_d = S_REQ;
`endif
                end
            end

            S_REQ: begin
                // The start pulse goes out even when flushed. The divider has
                // then been started, so its answer must still be absorbed in
                // DRAIN.
                div_valid = 1'b1;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end

            S_WAIT: begin
                result_ready = 1'b1;
                if (result_ok) begin
                    if (flush) begin
                        // The divider finished on the flush cycle. Nothing is
                        // left to drain, so drop the result here.
                        state_d = S_IDLE;
                    end else begin
                        wb_data_d = div_out;
                        state_d   = S_DONE;
                    end
                end else if (flush) begin
                    state_d = S_DRAIN;
                end
            end

            S_DONE: begin
                wb_valid = 1'b1;
                if (flush || wb_ready) begin
                    state_d = S_IDLE;
                end
            end

            S_DRAIN: begin
                result_ready = 1'b1;
                if (result_ok) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ex_stall    = in_valid & ~in_ready;
    assign div_type_o  = type_q;
    assign dividend_o  = dividend_q;
    assign divisor_o   = divisor_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = rd_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_ysyx_22050019_div_req.sv
module tb_ysyx_22050019_div_req;

    localparam int XLEN = 64;
    localparam int RIDX = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      in_funct3 = 3'd0;
    logic            in_word = 1'b0;
    logic [XLEN-1:0] in_rs1 = '0;
    logic [XLEN-1:0] in_rs2 = '0;
    logic [RIDX-1:0] in_rd = '0;
    logic            flush = 1'b0;
    logic            ex_stall;
    logic            div_valid;
    logic [7:0]      div_type_o;
    logic [XLEN-1:0] dividend_o;
    logic [XLEN-1:0] divisor_o;
    logic            div_stall = 1'b0;
    logic            result_ok = 1'b0;
    logic [XLEN-1:0] div_out = '0;
    logic            result_ready;
    logic            wb_valid;
    logic            wb_ready = 1'b0;
    logic [XLEN-1:0] wb_data;
    logic [RIDX-1:0] wb_rd;
    logic [2:0]      dbg_state;

    ysyx_22050019_div_req #(.XLEN(XLEN), .RIDX(RIDX)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct3(in_funct3), .in_word(in_word),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .flush(flush), .ex_stall(ex_stall),
        .div_valid(div_valid), .div_type_o(div_type_o), .dividend_o(dividend_o), .divisor_o(divisor_o),
        .div_stall(div_stall), .result_ok(result_ok), .div_out(div_out), .result_ready(result_ready),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
        .dbg_state_o(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // RV64M reference: plain arithmetic plus the ISA's /0 and overflow rules.
    function automatic logic [63:0] ref_div(input logic [2:0] f3, input logic w,
                                            input logic [63:0] a, input logic [63:0] b);
        logic signed [63:0] sa, sb, sq;
        logic signed [31:0] sa32, sb32, sq32;
        logic [31:0] ua32, ub32, r32;
        logic [63:0] r;
        sa = a; sb = b; ua32 = a[31:0]; ub32 = b[31:0]; sa32 = a[31:0]; sb32 = b[31:0];
        r = '0; r32 = '0;
        if (!w) begin
            case (f3)
                3'd4: if (b == 0) r = '1;
                      else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = a;
                      else begin sq = sa / sb; r = sq; end
                3'd5: if (b == 0) r = '1; else r = a / b;
                3'd6: if (b == 0) r = a;
                      else if (a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) r = '0;
                      else begin sq = sa % sb; r = sq; end
                3'd7: if (b == 0) r = a; else r = a % b;
                default: r = '0;
            endcase
        end else begin
            case (f3)
                3'd4: if (ub32 == 0) r32 = '1;
                      else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = ua32;
                      else begin sq32 = sa32 / sb32; r32 = sq32; end
                3'd5: if (ub32 == 0) r32 = '1; else r32 = ua32 / ub32;
                3'd6: if (ub32 == 0) r32 = ua32;
                      else if (ua32 == 32'h8000_0000 && ub32 == 32'hFFFF_FFFF) r32 = '0;
                      else begin sq32 = sa32 % sb32; r32 = sq32; end
                3'd7: if (ub32 == 0) r32 = ua32; else r32 = ua32 % ub32;
                default: r32 = '0;
            endcase
            r = {{32{r32[31]}}, r32};
        end
        return r;
    endfunction

    // One-hot type code from the divider interface table.
    function automatic logic [7:0] exp_type(input logic [2:0] f3, input logic w);
        case ({f3, w})
            4'b1000: return 8'h08;
            4'b1001: return 8'h01;
            4'b1010: return 8'h04;
            4'b1011: return 8'h02;
            4'b1100: return 8'h80;
            4'b1101: return 8'h10;
            4'b1110: return 8'h40;
            4'b1111: return 8'h20;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] model_result(input logic [7:0] t, input logic [63:0] a,
                                                 input logic [63:0] b);
        case (t)
            8'h08: return ref_div(3'd4, 1'b0, a, b);
            8'h01: return ref_div(3'd4, 1'b1, a, b);
            8'h04: return ref_div(3'd5, 1'b0, a, b);
            8'h02: return ref_div(3'd5, 1'b1, a, b);
            8'h80: return ref_div(3'd6, 1'b0, a, b);
            8'h10: return ref_div(3'd6, 1'b1, a, b);
            8'h40: return ref_div(3'd7, 1'b0, a, b);
            8'h20: return ref_div(3'd7, 1'b1, a, b);
            default: return 64'hDEAD_BEEF_0BAD_F00D;
        endcase
    endfunction

    // ---------------- divider model ----------------
    // Runs on the falling edge: it samples DUT outputs settled since the last
    // rising edge and drives its own outputs for the next one.
    int force_lat = 0;
    int last_lat = 1;
    int cnt = 0;
    int pulse_cnt = 0;
    int stab_err = 0;
    int proto_err = 0;
    logic busy = 1'b0;
    logic fire = 1'b0;
    logic [7:0]  cap_type = '0;
    logic [63:0] cap_a = '0, cap_b = '0, cap_res = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0; fire = 1'b0; result_ok = 1'b0; div_stall = 1'b0;
        end else begin
            if (fire) begin
                result_ok = 1'b0; div_stall = 1'b0; busy = 1'b0; fire = 1'b0;
            end
            if (div_valid) begin
                pulse_cnt++;
                if (busy) proto_err++;
                else begin
                    busy = 1'b1; div_stall = 1'b1;
                    cap_type = div_type_o; cap_a = dividend_o; cap_b = divisor_o;
                    cap_res = model_result(div_type_o, dividend_o, divisor_o);
                    cnt = (force_lat > 0) ? force_lat : int'($urandom_range(1, 5));
                    last_lat = cnt;
                end
            end else if (busy) begin
                if (div_type_o !== cap_type || dividend_o !== cap_a || divisor_o !== cap_b)
                    stab_err++;
                if (!result_ok) begin
                    cnt--;
                    if (cnt == 0) begin
                        result_ok = 1'b1;
                        div_out = cap_res;
                    end
                end
                fire = result_ok && result_ready;
            end
        end
    end

    // ---------------- driver tasks ----------------
    int c_acc = 0;

    // Called at a falling edge; returns one cycle after acceptance (+1).
    task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        int i;
        in_funct3 = f3; in_word = w; in_rs1 = a; in_rs2 = b; in_rd = rd; in_valid = 1'b1;
        for (i = 0; i < 20; i++) begin
            #1;
            if (in_ready) break;
            @(negedge clk);
        end
        if (i == 20) begin
            failures++;
            $display("FAIL accept_timeout: in_ready never rose");
        end
        c_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
    endtask

    task automatic wait_wb(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (wb_valid) begin
                ok = 1'b1;
                return;
            end
            @(negedge clk);
            #1;
        end
        failures++;
        $display("FAIL wb_timeout: wb_valid never rose");
    endtask

    task automatic drain_check(input string tag);
        bit seen_wb = 1'b0;
        int i;
        for (i = 0; i < 30; i++) begin
            if (wb_valid) seen_wb = 1'b1;
            if (in_ready) break;
            @(negedge clk);
            #1;
        end
        check({tag, "_wb_suppressed"}, 64'(seen_wb), 64'd0);
        check({tag, "_back_idle"}, 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd, input logic [7:0] etyp,
                         input logic [63:0] edata, input int hold, input string tag);
        int p0;
        int lat;
        bit ok;
        bit byp;
        logic [63:0] e;
`ifdef DIV_REQ_BYPASS_EN
        byp = w ? (b[31:0] == 32'd1) : (b == 64'd1);
`else
        byp = 1'b0;
`endif
        exp_q.push_back(edata);
        @(negedge clk);
        p0 = pulse_cnt;
        issue(f3, w, a, b, rd);
        wait_wb(ok);
        e = exp_q.pop_front();
        if (ok) begin
            lat = cyc - c_acc;
            check({tag, "_data"}, wb_data, e);
            check({tag, "_rd"}, 64'(wb_rd), 64'(rd));
            check({tag, "_pulses"}, 64'(pulse_cnt - p0), byp ? 64'd0 : 64'd1);
            check({tag, "_latency"}, 64'(lat), byp ? 64'd1 : 64'(2 + last_lat));
            if (!byp) begin
                check({tag, "_type"}, 64'(cap_type), 64'(etyp));
                check({tag, "_dividend"}, cap_a, a);
                check({tag, "_divisor"}, cap_b, b);
            end
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                #1;
                check({tag, "_hold_valid"}, 64'(wb_valid), 64'd1);
                check({tag, "_hold_data"}, wb_data, e);
            end
            wb_ready = 1'b1;
            @(negedge clk);
            wb_ready = 1'b0;
            #1;
            check({tag, "_wb_drop"}, 64'(wb_valid), 64'd0);
            check({tag, "_ready_again"}, 64'(in_ready), 64'd1);
        end
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [7:0]  typ;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[9];

    function automatic logic [63:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return 64'hFFFF_FFFF_FFFF_FFFF;
            3: return 64'h8000_0000_0000_0000;
            4: return 64'h0000_0000_8000_0000;
            5: return {32'h0, $urandom};
            6: return 64'h0000_0000_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // ---------------- main test ----------------
    initial begin
        int p0;
        bit ok;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a, b;
        logic [4:0]  rd;

        vecs[0] = '{3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 5'd1, 8'h08, 64'hFFFF_FFFF_FFFF_FFFA};
        vecs[1] = '{3'd6, 1'b1, 64'h0000_0000_8000_0007, 64'd0, 5'd2, 8'h10, 64'hFFFF_FFFF_8000_0007};
        vecs[2] = '{3'd5, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd2, 5'd3, 8'h02, 64'h0000_0000_7FFF_FFFF};
        vecs[3] = '{3'd5, 1'b0, 64'd100, 64'd7, 5'd4, 8'h04, 64'd14};
        vecs[4] = '{3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd3, 5'd5, 8'h80, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5] = '{3'd7, 1'b0, 64'd100, 64'd7, 5'd6, 8'h40, 64'd2};
        vecs[6] = '{3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd7, 8'h01,
                    64'hFFFF_FFFF_8000_0000};
        vecs[7] = '{3'd7, 1'b1, 64'h0000_0001_0000_000A, 64'd3, 5'd8, 8'h20, 64'd1};
        vecs[8] = '{3'd4, 1'b0, 64'd5, 64'd0, 5'd31, 8'h08, 64'hFFFF_FFFF_FFFF_FFFF};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_div_valid", 64'(div_valid), 64'd0);
        check("rst_wb_valid", 64'(wb_valid), 64'd0);
        check("rst_result_ready", 64'(result_ready), 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_type", 64'(div_type_o), 64'd0);
        check("rst_dividend", dividend_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // table vectors
        for (int i = 0; i < 9; i++)
            do_op(vecs[i].f3, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].rd, vecs[i].typ,
                  vecs[i].res, i % 3, $sformatf("vec%0d", i));

        // WB back-pressure: result held, EX stalled, next op only after release
        @(negedge clk);
        issue(3'd5, 1'b0, 64'd100, 64'd7, 5'd9);
        wait_wb(ok);
        check("bp_data", wb_data, 64'd14);
        in_valid = 1'b1; in_funct3 = 3'd4; in_word = 1'b0; in_rs1 = 64'd9; in_rs2 = 64'd2; in_rd = 5'd4;
        #1;
        for (int h = 0; h < 5; h++) begin
            check("bp_wb_valid", 64'(wb_valid), 64'd1);
            check("bp_wb_data", wb_data, 64'd14);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            check("bp_ex_stall", 64'(ex_stall), 64'd1);
            @(negedge clk);
            #1;
        end
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;
        #1;
        check("bp_release_wb", 64'(wb_valid), 64'd0);
        check("bp_release_ready", 64'(in_ready), 64'd1);
        check("bp_release_stall", 64'(ex_stall), 64'd0);
        c_acc = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_second_req", 64'(div_valid), 64'd1);
        wait_wb(ok);
        check("bp_second_data", wb_data, 64'd4);
        wb_ready = 1'b1;
        @(negedge clk);
        wb_ready = 1'b0;

        // flush while in REQ: start still goes out, result drained
        force_lat = 4;
        @(negedge clk);
        p0 = pulse_cnt;
        issue(3'd4, 1'b0, 64'd50, 64'd5, 5'd3);
        check("flreq_div_valid", 64'(div_valid), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flreq_no_repulse", 64'(div_valid), 64'd0);
        check("flreq_result_ready", 64'(result_ready), 64'd1);
        drain_check("flreq");
        check("flreq_pulses", 64'(pulse_cnt - p0), 64'd1);

        // flush two cycles after accept (WAIT) -> DRAIN, then DIVU 100/7
        force_lat = 5;
        @(negedge clk);
        issue(3'd4, 1'b0, 64'd77, 64'd7, 5'd3);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flwait_result_ready", 64'(result_ready), 64'd1);
        check("flwait_wb_valid", 64'(wb_valid), 64'd0);
        drain_check("flwait");
        force_lat = 0;
        do_op(3'd5, 1'b0, 64'd100, 64'd7, 5'd10, 8'h04, 64'd14, 1, "after_flush");

        // flush in WAIT on the same cycle as result_ok -> straight to IDLE
        force_lat = 1;
        @(negedge clk);
        issue(3'd7, 1'b0, 64'd33, 64'd5, 5'd11);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flok_idle", 64'(in_ready), 64'd1);
        check("flok_no_wb", 64'(wb_valid), 64'd0);

        // flush in DONE -> wb_valid drops next cycle
        force_lat = 2;
        @(negedge clk);
        issue(3'd6, 1'b1, 64'd29, 64'd4, 5'd12);
        wait_wb(ok);
        check("fldone_data", wb_data, 64'd1);
        flush = 1'b1;
        #1;
        check("fldone_valid_before", 64'(wb_valid), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("fldone_valid_after", 64'(wb_valid), 64'd0);
        check("fldone_idle", 64'(in_ready), 64'd1);
        force_lat = 0;

        // flush in IDLE blocks acceptance; illegal funct3 never issues
        @(negedge clk);
        p0 = pulse_cnt;
        in_valid = 1'b1; in_funct3 = 3'd4; in_rs1 = 64'd8; in_rs2 = 64'd2; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        in_funct3 = 3'b001;
        #1;
        check("flidle_still_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("illegal_still_idle", 64'(in_ready), 64'd1);
        @(negedge clk);
        #1;
        check("flidle_illegal_no_pulse", 64'(pulse_cnt - p0), 64'd0);

        // reset in the middle of an operation
        force_lat = 5;
        @(negedge clk);
        issue(3'd4, 1'b0, 64'd99, 64'd9, 5'd13);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_result_ready", 64'(result_ready), 64'd0);
        check("midrst_wb_valid", 64'(wb_valid), 64'd0);
        check("midrst_wb_data", wb_data, 64'd0);
        check("midrst_type", 64'(div_type_o), 64'd0);
        rst_n = 1'b1;
        force_lat = 0;
        do_op(3'd4, 1'b0, 64'd99, 64'd9, 5'd13, 8'h08, 64'd11, 0, "after_rst");

`ifdef DIV_REQ_BYPASS_EN
        do_op(3'd6, 1'b0, 64'd55, 64'd1, 5'd14, 8'h80, 64'd0, 0, "bypass_rem");
        do_op(3'd4, 1'b1, 64'h0000_0000_8000_0001, 64'h7_0000_0001, 5'd15, 8'h01,
              64'hFFFF_FFFF_8000_0001, 0, "bypass_divw");
`endif

        // randomized ops against the reference model
        for (int i = 0; i < 40; i++) begin
            f3 = 3'd4 + 3'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            a  = pick_op();
            b  = pick_op();
            rd = 5'($urandom_range(0, 31));
            do_op(f3, w, a, b, rd, exp_type(f3, w), ref_div(f3, w, a, b),
                  int'($urandom_range(0, 2)), $sformatf("rnd%0d", i));
        end

        check("operand_stability", 64'(stab_err), 64'd0);
        check("no_start_while_busy", 64'(proto_err), 64'd0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: simulation did not complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
